// File: rtl/rtc_timer_core_if.sv
// Bundle of the rtc_timer_core control inputs and display/timer outputs.
// The alarm signals exist only when RTC_ALARM_EN is defined.
// clk and reset stay plain ports on the core.
interface rtc_timer_core_if #(
  parameter int TMR_W = 16
);
  // Time-of-day control
  logic             mode_12h;
  logic             set_en;
  logic [4:0]       set_h;
  logic [5:0]       set_m;
  logic [5:0]       set_s;

  // Timer control
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_secs;
  logic             tmr_start;
  logic             tmr_stop;

  // Display and status
  logic             tick;
  logic [7:0]       hr_bcd;
  logic [7:0]       min_bcd;
  logic [7:0]       sec_bcd;
  logic             pm;
  logic             tmr_busy;
  logic [TMR_W-1:0] tmr_remain;
  logic             tmr_done;
  logic             buzzer;

`ifdef RTC_ALARM_EN
  logic             alarm_wr;
  logic [4:0]       alarm_h;
  logic [5:0]       alarm_m;
  logic             alarm_on;
  logic             alarm_hit;
`endif

  // Controller side: drives the requests and observes the status
  modport master (
    output mode_12h, set_en, set_h, set_m, set_s,
    output tmr_load, tmr_secs, tmr_start, tmr_stop,
`ifdef RTC_ALARM_EN
    output alarm_wr, alarm_h, alarm_m, alarm_on,
    input  alarm_hit,
`endif
    input  tick, hr_bcd, min_bcd, sec_bcd, pm,
    input  tmr_busy, tmr_remain, tmr_done, buzzer
  );

  // Core side: the reverse view
  modport slave (
    input  mode_12h, set_en, set_h, set_m, set_s,
    input  tmr_load, tmr_secs, tmr_start, tmr_stop,
`ifdef RTC_ALARM_EN
    input  alarm_wr, alarm_h, alarm_m, alarm_on,
    output alarm_hit,
`endif
    output tick, hr_bcd, min_bcd, sec_bcd, pm,
    output tmr_busy, tmr_remain, tmr_done, buzzer
  );
endinterface

// File: rtl/rtc_timer_core.sv
// rtc_timer_core: time-of-day clock with 12/24 h BCD display and a
// countdown timer that drives a buzzer for BUZZ_SECS seconds on expiry.
// A prescaler divides clk by TICK_DIV to give the 1 Hz tick.
// Optional feature macro: RTC_ALARM_EN adds a daily HH:MM alarm that
// shares the RING state (and buzzer) with the timer.
module rtc_timer_core #(
  parameter int TICK_DIV  = 24000000,
  parameter int TMR_W     = 16,
  parameter int BUZZ_SECS = 10
) (
  input logic              clk,
  input logic              reset,
  rtc_timer_core_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BUZZ_SECS > 1) ? $clog2(BUZZ_SECS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RING = 2'd2
  } tmr_state_t;

  // Binary value 0..63 to two BCD digits
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  logic [PW-1:0]    presc;
  logic             tick_now;

  logic [4:0]       hour;
  logic [5:0]       minute;
  logic [5:0]       second;
  logic [4:0]       next_hr;
  logic [5:0]       next_min;
  logic [5:0]       next_sec;
  logic             set_valid;
  logic [4:0]       hr_disp;

  logic [7:0]       hr_q;
  logic [7:0]       min_q;
  logic [7:0]       sec_q;
  logic             pm_q;

  tmr_state_t       state;
  logic [TMR_W-1:0] remain;
  logic [BW-1:0]    buzz_cnt;
  logic             done_q;
  logic             alarm_trig;

  assign tick_now  = (presc == PW'(TICK_DIV - 1));

  assign set_valid = bus.set_en && (bus.set_h <= 5'd23) &&
                     (bus.set_m <= 6'd59) && (bus.set_s <= 6'd59);

  // Free-running prescaler; a valid time load restarts the second
  always_ff @(posedge clk) begin
    if (reset || set_valid) begin
      presc <= '0;
    end else if (tick_now) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Time that the clock would hold after this cycle's tick, with carries
  always_comb begin
    next_sec = second;
    next_min = minute;
    next_hr  = hour;
    if (tick_now) begin
      if (second == 6'd59) begin
        next_sec = 6'd0;
        if (minute == 6'd59) begin
          next_min = 6'd0;
          if (hour == 5'd23) begin
            next_hr = 5'd0;
          end else begin
            next_hr = hour + 5'd1;
          end
        end else begin
          next_min = minute + 6'd1;
        end
      end else begin
        next_sec = second + 6'd1;
      end
    end
  end

  // Time-of-day registers; a valid load overrides a coincident tick
  always_ff @(posedge clk) begin
    if (reset) begin
      hour   <= 5'd0;
      minute <= 6'd0;
      second <= 6'd0;
    end else if (set_valid) begin
      hour   <= bus.set_h;
      minute <= bus.set_m;
      second <= bus.set_s;
    end else begin
      hour   <= next_hr;
      minute <= next_min;
      second <= next_sec;
    end
  end

  // Hour as shown on the display: 0 becomes 12, 13..23 fold down in 12 h mode
  always_comb begin
    hr_disp = hour;
    if (bus.mode_12h) begin
      if (hour == 5'd0) begin
        hr_disp = 5'd12;
      end else if (hour > 5'd12) begin
        hr_disp = hour - 5'd12;
      end
    end
  end

  // Registered BCD display and pm flag, one cycle behind the binary time
  always_ff @(posedge clk) begin
    if (reset) begin
      hr_q  <= 8'h00;
      min_q <= 8'h00;
      sec_q <= 8'h00;
      pm_q  <= 1'b0;
    end else begin
      hr_q  <= to_bcd({1'b0, hr_disp});
      min_q <= to_bcd(minute);
      sec_q <= to_bcd(second);
      pm_q  <= (hour >= 5'd12);
    end
  end

`ifdef RTC_ALARM_EN
  logic [4:0] alarm_h_q;
  logic [5:0] alarm_m_q;
  logic       alarm_hit_q;

  // The alarm fires only when a real tick carries the time onto HH:MM:00
  assign alarm_trig = bus.alarm_on && tick_now && !set_valid &&
                      (next_sec == 6'd0) && (next_min == alarm_m_q) &&
                      (next_hr == alarm_h_q);

  // Alarm time latch (out-of-range writes are dropped) and hit pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_h_q   <= 5'd0;
      alarm_m_q   <= 6'd0;
      alarm_hit_q <= 1'b0;
    end else begin
      alarm_hit_q <= alarm_trig;
      if (bus.alarm_wr && (bus.alarm_h <= 5'd23) && (bus.alarm_m <= 6'd59)) begin
        alarm_h_q <= bus.alarm_h;
        alarm_m_q <= bus.alarm_m;
      end
    end
  end

  assign bus.alarm_hit = alarm_hit_q;
`else
  assign alarm_trig = 1'b0;
`endif

  // Timer FSM: IDLE loads/starts, RUN counts down on ticks, RING buzzes
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      remain   <= '0;
      buzz_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tmr_load) begin
            remain <= bus.tmr_secs;
          end
          if (!bus.tmr_stop && bus.tmr_start && (remain != '0)) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.tmr_stop) begin
            state <= IDLE;
          end else if (tick_now) begin
            remain <= remain - TMR_W'(1);
            if (remain == TMR_W'(1)) begin
              state    <= RING;
              buzz_cnt <= '0;
              done_q   <= 1'b1;
            end
          end
        end
        RING: begin
          if (bus.tmr_stop) begin
            state <= IDLE;
          end else if (tick_now) begin
            if (buzz_cnt == BW'(BUZZ_SECS - 1)) begin
              state <= IDLE;
            end else begin
              buzz_cnt <= buzz_cnt + BW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (alarm_trig && !bus.tmr_stop) begin
        state    <= RING;
        buzz_cnt <= '0;
      end
    end
  end

  assign bus.tick       = tick_now;
  assign bus.hr_bcd     = hr_q;
  assign bus.min_bcd    = min_q;
  assign bus.sec_bcd    = sec_q;
  assign bus.pm         = pm_q;
  assign bus.tmr_busy   = (state == RUN);
  assign bus.buzzer     = (state == RING);
  assign bus.tmr_remain = remain;
  assign bus.tmr_done   = done_q;

endmodule

// File: tb/tb_rtc_timer_core.sv
// Testbench for rtc_timer_core (TICK_DIV=4, BUZZ_SECS=3, alarm disabled).
// A seconds-of-day / countdown reference model predicts every output.
module tb_rtc_timer_core;

  localparam int TICK_DIV  = 4;
  localparam int TMR_W     = 16;
  localparam int BUZZ_SECS = 3;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_tod;
  int         m_cyc;
  int         m_tstate;
  int         m_remain;
  int         m_ring_left;
  logic [7:0] e_hr;
  logic [7:0] e_min;
  logic [7:0] e_sec;
  logic       e_pm;
  logic       e_done;

  rtc_timer_core_if #(.TMR_W(TMR_W)) bus ();

  rtc_timer_core #(
    .TICK_DIV (TICK_DIV),
    .TMR_W    (TMR_W),
    .BUZZ_SECS(BUZZ_SECS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd8(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  // Advance the model by one clock edge using the inputs the DUT saw
  task automatic model_update();
    int  h;
    int  mi;
    int  s;
    int  dh;
    int  old_rem;
    bit  tk;
    if (reset) begin
      m_tod = 0; m_cyc = 0; m_tstate = 0; m_remain = 0; m_ring_left = 0;
      e_hr = 8'h00; e_min = 8'h00; e_sec = 8'h00; e_pm = 1'b0; e_done = 1'b0;
      return;
    end
    tk = (m_cyc == TICK_DIV - 1);
    h  = m_tod / 3600;
    mi = (m_tod / 60) % 60;
    s  = m_tod % 60;
    dh = h;
    if (bus.mode_12h) dh = (h % 12 == 0) ? 12 : h % 12;
    e_hr  = bcd8(dh);
    e_min = bcd8(mi);
    e_sec = bcd8(s);
    e_pm  = (h >= 12);
    if (bus.set_en && bus.set_h <= 23 && bus.set_m <= 59 && bus.set_s <= 59) begin
      m_tod = int'(bus.set_h) * 3600 + int'(bus.set_m) * 60 + int'(bus.set_s);
      m_cyc = 0;
    end else begin
      m_cyc = (m_cyc + 1) % TICK_DIV;
      if (tk) m_tod = (m_tod + 1) % 86400;
    end
    e_done  = 1'b0;
    old_rem = m_remain;
    case (m_tstate)
      0: begin
        if (bus.tmr_load) m_remain = int'(bus.tmr_secs);
        if (!bus.tmr_stop && bus.tmr_start && old_rem != 0) m_tstate = 1;
      end
      1: begin
        if (bus.tmr_stop) m_tstate = 0;
        else if (tk) begin
          m_remain = m_remain - 1;
          if (m_remain == 0) begin
            m_tstate = 2; m_ring_left = BUZZ_SECS; e_done = 1'b1;
          end
        end
      end
      default: begin
        if (bus.tmr_stop) m_tstate = 0;
        else if (tk) begin
          m_ring_left = m_ring_left - 1;
          if (m_ring_left == 0) m_tstate = 0;
        end
      end
    endcase
  endtask

  // One clock edge, model update, then settle before sampling
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mode_12h = 1'b1;
    step();
    step();
    checks += 9;
    if (bus.tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick: got %0b want 0", bus.tick); end
    if (bus.hr_bcd !== 8'h00) begin errors++; $display("[TB] FAIL reset_hr: got %0h want 00", bus.hr_bcd); end
    if (bus.min_bcd !== 8'h00) begin errors++; $display("[TB] FAIL reset_min: got %0h want 00", bus.min_bcd); end
    if (bus.sec_bcd !== 8'h00) begin errors++; $display("[TB] FAIL reset_sec: got %0h want 00", bus.sec_bcd); end
    if (bus.pm !== 1'b0) begin errors++; $display("[TB] FAIL reset_pm: got %0b want 0", bus.pm); end
    if (bus.tmr_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", bus.tmr_busy); end
    if (bus.tmr_remain !== '0) begin errors++; $display("[TB] FAIL reset_remain: got %0d want 0", bus.tmr_remain); end
    if (bus.tmr_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b want 0", bus.tmr_done); end
    if (bus.buzzer !== 1'b0) begin errors++; $display("[TB] FAIL reset_buzzer: got %0b want 0", bus.buzzer); end
    reset = 1'b0;
    bus.mode_12h = 1'b0;
  endtask

  task automatic test_tick();
    int n_ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (bus.tick !== (m_cyc == TICK_DIV - 1)) begin
        errors++;
        $display("[TB] FAIL tick_cycle%0d: got %0b want %0b", i, bus.tick, (m_cyc == TICK_DIV - 1));
      end
      if (bus.tick === 1'b1) n_ticks++;
    end
    checks++;
    if (n_ticks != 3) begin errors++; $display("[TB] FAIL tick_count: got %0d want 3", n_ticks); end
  endtask

  task automatic test_rollover();
    bus.set_h = 5'd23; bus.set_m = 6'd59; bus.set_s = 6'd58; bus.set_en = 1'b1;
    step();
    bus.set_en = 1'b0;
    step();
    checks += 2;
    if (bus.hr_bcd !== 8'h23) begin errors++; $display("[TB] FAIL set_hr: got %0h want 23", bus.hr_bcd); end
    if (bus.pm !== 1'b1) begin errors++; $display("[TB] FAIL set_pm: got %0b want 1", bus.pm); end
    for (int i = 0; i < 2 * TICK_DIV; i++) step();
    checks += 4;
    if (bus.hr_bcd !== 8'h00) begin errors++; $display("[TB] FAIL roll_hr: got %0h want 00", bus.hr_bcd); end
    if (bus.min_bcd !== 8'h00) begin errors++; $display("[TB] FAIL roll_min: got %0h want 00", bus.min_bcd); end
    if (bus.sec_bcd !== 8'h00) begin errors++; $display("[TB] FAIL roll_sec: got %0h want 00", bus.sec_bcd); end
    if (bus.pm !== 1'b0) begin errors++; $display("[TB] FAIL roll_pm: got %0b want 0", bus.pm); end
  endtask

  task automatic test_12h();
    bus.mode_12h = 1'b1;
    bus.set_h = 5'd0; bus.set_m = 6'd0; bus.set_s = 6'd0; bus.set_en = 1'b1;
    step();
    bus.set_en = 1'b0;
    step();
    checks += 2;
    if (bus.hr_bcd !== 8'h12) begin errors++; $display("[TB] FAIL h12_midnight: got %0h want 12", bus.hr_bcd); end
    if (bus.pm !== 1'b0) begin errors++; $display("[TB] FAIL h12_midnight_pm: got %0b want 0", bus.pm); end
    bus.set_h = 5'd13; bus.set_m = 6'd5; bus.set_s = 6'd0; bus.set_en = 1'b1;
    step();
    bus.set_en = 1'b0;
    step();
    checks += 3;
    if (bus.hr_bcd !== 8'h01) begin errors++; $display("[TB] FAIL h12_13h: got %0h want 01", bus.hr_bcd); end
    if (bus.min_bcd !== 8'h05) begin errors++; $display("[TB] FAIL h12_13h_min: got %0h want 05", bus.min_bcd); end
    if (bus.pm !== 1'b1) begin errors++; $display("[TB] FAIL h12_13h_pm: got %0b want 1", bus.pm); end
    bus.mode_12h = 1'b0;
  endtask

  task automatic test_timer();
    int n_done = 0;
    int n_buzz = 0;
    bus.tmr_secs = TMR_W'(3); bus.tmr_load = 1'b1;
    step();
    bus.tmr_load = 1'b0; bus.tmr_start = 1'b1;
    step();
    bus.tmr_start = 1'b0;
    checks++;
    if (bus.tmr_busy !== 1'b1) begin errors++; $display("[TB] FAIL timer_start_busy: got %0b want 1", bus.tmr_busy); end
    for (int i = 0; i < 40; i++) begin
      step();
      checks += 4;
      if (bus.tmr_remain !== TMR_W'(m_remain)) begin errors++; $display("[TB] FAIL timer_remain c%0d: got %0d want %0d", i, bus.tmr_remain, m_remain); end
      if (bus.tmr_done !== e_done) begin errors++; $display("[TB] FAIL timer_done c%0d: got %0b want %0b", i, bus.tmr_done, e_done); end
      if (bus.tmr_busy !== (m_tstate == 1)) begin errors++; $display("[TB] FAIL timer_busy c%0d: got %0b want %0b", i, bus.tmr_busy, (m_tstate == 1)); end
      if (bus.buzzer !== (m_tstate == 2)) begin errors++; $display("[TB] FAIL timer_buzzer c%0d: got %0b want %0b", i, bus.buzzer, (m_tstate == 2)); end
      if (bus.tmr_done === 1'b1) n_done++;
      if (bus.buzzer === 1'b1) n_buzz++;
    end
    checks += 2;
    if (n_done != 1) begin errors++; $display("[TB] FAIL timer_done_count: got %0d want 1", n_done); end
    if (n_buzz != BUZZ_SECS * TICK_DIV) begin errors++; $display("[TB] FAIL timer_buzz_cycles: got %0d want %0d", n_buzz, BUZZ_SECS * TICK_DIV); end
  endtask

  task automatic test_pause();
    int guard;
    bus.tmr_secs = TMR_W'(5); bus.tmr_load = 1'b1;
    step();
    bus.tmr_load = 1'b0; bus.tmr_start = 1'b1;
    step();
    bus.tmr_start = 1'b0;
    guard = 0;
    while (m_remain != 3 && guard < 30) begin step(); guard++; end
    checks++;
    if (guard >= 30) begin errors++; $display("[TB] FAIL pause_wait: model did not reach 3 within bound, remain %0d", m_remain); end
    bus.tmr_stop = 1'b1;
    step();
    bus.tmr_stop = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks += 2;
    if (bus.tmr_remain !== TMR_W'(3)) begin errors++; $display("[TB] FAIL pause_remain: got %0d want 3", bus.tmr_remain); end
    if (bus.tmr_busy !== 1'b0) begin errors++; $display("[TB] FAIL pause_busy: got %0b want 0", bus.tmr_busy); end
    bus.tmr_start = 1'b1;
    step();
    bus.tmr_start = 1'b0;
    checks += 2;
    if (bus.tmr_busy !== 1'b1) begin errors++; $display("[TB] FAIL resume_busy: got %0b want 1", bus.tmr_busy); end
    if (bus.tmr_remain !== TMR_W'(3)) begin errors++; $display("[TB] FAIL resume_remain: got %0d want 3", bus.tmr_remain); end
    guard = 0;
    while (m_remain != 2 && guard < 10) begin step(); guard++; end
    checks++;
    if (bus.tmr_remain !== TMR_W'(2) || guard >= 10) begin errors++; $display("[TB] FAIL resume_count: got %0d want 2", bus.tmr_remain); end
    bus.tmr_stop = 1'b1;
    step();
    bus.tmr_stop = 1'b0;
    bus.tmr_secs = '0; bus.tmr_load = 1'b1;
    step();
    bus.tmr_load = 1'b0; bus.tmr_start = 1'b1;
    step();
    bus.tmr_start = 1'b0;
    checks += 2;
    if (bus.tmr_busy !== 1'b0) begin errors++; $display("[TB] FAIL start_zero_busy: got %0b want 0", bus.tmr_busy); end
    if (bus.tmr_remain !== '0) begin errors++; $display("[TB] FAIL start_zero_remain: got %0d want 0", bus.tmr_remain); end
  endtask

  task automatic test_set_rules();
    int guard;
    bus.set_h = 5'd7; bus.set_m = 6'd60; bus.set_s = 6'd10; bus.set_en = 1'b1;
    step();
    bus.set_en = 1'b0;
    step();
    checks += 3;
    if (bus.hr_bcd !== e_hr) begin errors++; $display("[TB] FAIL bad_set_hr: got %0h want %0h", bus.hr_bcd, e_hr); end
    if (bus.min_bcd !== e_min) begin errors++; $display("[TB] FAIL bad_set_min: got %0h want %0h", bus.min_bcd, e_min); end
    if (bus.sec_bcd !== e_sec) begin errors++; $display("[TB] FAIL bad_set_sec: got %0h want %0h", bus.sec_bcd, e_sec); end
    guard = 0;
    while (m_cyc != TICK_DIV - 1 && guard < 10) begin step(); guard++; end
    checks++;
    if (bus.tick !== 1'b1) begin errors++; $display("[TB] FAIL set_tick_align: got %0b want 1", bus.tick); end
    bus.set_h = 5'd10; bus.set_m = 6'd20; bus.set_s = 6'd30; bus.set_en = 1'b1;
    step();
    bus.set_en = 1'b0;
    step();
    checks += 3;
    if (bus.hr_bcd !== 8'h10) begin errors++; $display("[TB] FAIL set_vs_tick_hr: got %0h want 10", bus.hr_bcd); end
    if (bus.min_bcd !== 8'h20) begin errors++; $display("[TB] FAIL set_vs_tick_min: got %0h want 20", bus.min_bcd); end
    if (bus.sec_bcd !== 8'h30) begin errors++; $display("[TB] FAIL set_vs_tick_sec: got %0h want 30", bus.sec_bcd); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      bus.set_en    = ($urandom_range(0, 39) == 0);
      bus.set_h     = 5'($urandom_range(0, 31));
      bus.set_m     = 6'($urandom_range(0, 63));
      bus.set_s     = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) bus.mode_12h = ~bus.mode_12h;
      bus.tmr_load  = ($urandom_range(0, 9) == 0);
      bus.tmr_secs  = TMR_W'($urandom_range(0, 6));
      bus.tmr_start = ($urandom_range(0, 7) == 0);
      bus.tmr_stop  = ($urandom_range(0, 24) == 0);
      step();
      checks++;
      if (bus.tick !== (m_cyc == TICK_DIV - 1) || bus.hr_bcd !== e_hr ||
          bus.min_bcd !== e_min || bus.sec_bcd !== e_sec || bus.pm !== e_pm ||
          bus.tmr_remain !== TMR_W'(m_remain) || bus.tmr_done !== e_done ||
          bus.tmr_busy !== (m_tstate == 1) || bus.buzzer !== (m_tstate == 2)) begin
        errors++;
        $display("[TB] FAIL random c%0d: got tick=%0b hr=%0h min=%0h sec=%0h pm=%0b rem=%0d done=%0b busy=%0b buz=%0b want tick=%0b hr=%0h min=%0h sec=%0h pm=%0b rem=%0d done=%0b busy=%0b buz=%0b",
                 i, bus.tick, bus.hr_bcd, bus.min_bcd, bus.sec_bcd, bus.pm, bus.tmr_remain,
                 bus.tmr_done, bus.tmr_busy, bus.buzzer,
                 (m_cyc == TICK_DIV - 1), e_hr, e_min, e_sec, e_pm, m_remain,
                 e_done, (m_tstate == 1), (m_tstate == 2));
      end
    end
    bus.set_en = 1'b0; bus.tmr_load = 1'b0; bus.tmr_start = 1'b0; bus.tmr_stop = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.mode_12h  = 1'b0;
    bus.set_en    = 1'b0;
    bus.set_h     = 5'd0;
    bus.set_m     = 6'd0;
    bus.set_s     = 6'd0;
    bus.tmr_load  = 1'b0;
    bus.tmr_secs  = '0;
    bus.tmr_start = 1'b0;
    bus.tmr_stop  = 1'b0;
    m_tod = 0; m_cyc = 0; m_tstate = 0; m_remain = 0; m_ring_left = 0;
    e_hr = 8'h00; e_min = 8'h00; e_sec = 8'h00; e_pm = 1'b0; e_done = 1'b0;
    #2;
    test_reset();
    test_tick();
    test_rollover();
    test_12h();
    test_timer();
    test_pause();
    test_set_rules();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
